// File: rtl/spi_cmd_proto_pkg.sv
// Shared definitions for the SPI command protocol decoder: command codes,
// FSM encoding and status-byte layout.
package spi_cmd_proto_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_WR     = 3'd4,
      ST_RD     = 3'd5,
      ST_IGNORE = 3'd6
   } state_e;

   localparam int STAT_INVALID_BIT = 0;
   localparam int STAT_ABORTED_BIT = 1;
   localparam int STAT_CNT_LSB     = 4;
   localparam int STAT_CNT_W       = 4;

   function automatic logic [7:0] pack_status(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic aborted,
                                              input logic invalid);
      logic [7:0] s;
      s = 8'h00;
      s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
      s[STAT_ABORTED_BIT]           = aborted;
      s[STAT_INVALID_BIT]           = invalid;
      return s;
   endfunction

endpackage

// File: rtl/spi_cmd_proto_status.sv
// Frame counter and last-frame flags, presented as the byte shifted out during
// the command byte. Only built when SPI_CMD_PROTO_STATUS_EN is defined.
`ifdef SPI_CMD_PROTO_STATUS_EN
module spi_cmd_proto_status
   import spi_cmd_proto_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       csn_rise_i,
   input  state_e     state_i,
   input  state_e     state_nxt_i,
   output logic [7:0] status_o
);

   logic [STAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  aborted_q, aborted_d;
   logic                  invalid_q, invalid_d;
   logic                  frame_inv_q, frame_inv_d;

   always_comb begin
      cnt_d       = cnt_q;
      aborted_d   = aborted_q;
      invalid_d   = invalid_q;
      frame_inv_d = frame_inv_q;
      if (state_i == ST_CMD && state_nxt_i == ST_IGNORE) frame_inv_d = 1'b1;
      // Flags describe the frame that just closed, so they only move on csn_rise.
      if (csn_rise_i) begin
         cnt_d       = cnt_q + 1'b1;
         aborted_d   = (state_i == ST_ADDR) || (state_i == ST_DUMMY);
         invalid_d   = frame_inv_q;
         frame_inv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         aborted_q   <= 1'b0;
         invalid_q   <= 1'b0;
         frame_inv_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         aborted_q   <= aborted_d;
         invalid_q   <= invalid_d;
         frame_inv_q <= frame_inv_d;
      end
   end

   assign status_o = pack_status(cnt_q, aborted_q, invalid_q);

endmodule
`endif

// File: rtl/spi_cmd_proto.sv
// CS-framed command/address/data decoder driving a single-cycle register bus.
// Optional status byte on the command slot: define SPI_CMD_PROTO_STATUS_EN.
module spi_cmd_proto
   import spi_cmd_proto_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_stb,
   output logic [7:0]        out_data,
   input  logic              out_ack,
   input  logic              csn_state,
   input  logic              csn_rise,
   input  logic              csn_fall,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic [7:0]        bus_rdata
);

   state_e            state_q, state_d;
   logic              rd_cmd_q, rd_cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        out_q, out_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic              re_pend_q, re_pend_d;
   logic              inc_pend_q, inc_pend_d;
   logic              rd_vld_q, rd_vld_d;
   logic              stb_ok;
   logic [7:0]        status_byte;

`ifdef SPI_CMD_PROTO_STATUS_EN
   spi_cmd_proto_status u_status (
      .clk         (clk),
      .rst         (rst),
      .csn_rise_i  (csn_rise),
      .state_i     (state_q),
      .state_nxt_i (state_d),
      .status_o    (status_byte)
   );
`else
   assign status_byte = 8'h00;
`endif

   assign stb_ok = in_stb & ~csn_state;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      rd_cmd_d   = rd_cmd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      out_d      = out_q;
      we_d       = 1'b0;
      re_d       = re_pend_q;
      re_pend_d  = 1'b0;
      inc_pend_d = 1'b0;
      rd_vld_d   = re_q;

      if (inc_pend_q) addr_d = addr_q + ADDR_W'(1);

      // Frame edges win over any byte in the same cycle; in-flight reads are dropped.
      if (csn_rise) begin
         state_d  = ST_IDLE;
         out_d    = 8'h00;
         re_d     = 1'b0;
         rd_vld_d = 1'b0;
      end else if (csn_fall) begin
         state_d  = ST_CMD;
         out_d    = status_byte;
         re_d     = 1'b0;
         rd_vld_d = 1'b0;
      end else begin
         if (rd_vld_q && (state_q == ST_DUMMY || state_q == ST_RD)) out_d = bus_rdata;

         case (state_q)
            ST_CMD: begin
               if (stb_ok) begin
                  out_d = 8'h00;
                  if (in_data == CMD_WRITE || in_data == CMD_READ) begin
                     rd_cmd_d = (in_data == CMD_READ);
                     state_d  = ST_ADDR;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_ADDR: begin
               if (stb_ok) begin
                  addr_d = in_data[ADDR_W-1:0];
                  if (rd_cmd_q) begin
                     state_d = ST_DUMMY;
                     re_d    = 1'b1;
                  end else begin
                     state_d = ST_WR;
                  end
               end
            end
            ST_DUMMY: begin
               if (stb_ok) state_d = ST_RD;
            end
            ST_WR: begin
               if (stb_ok) begin
                  we_d       = 1'b1;
                  wdata_d    = in_data;
                  inc_pend_d = 1'b1;
               end
            end
            ST_RD: begin
               // Prefetch the next byte as soon as the core has taken the current one.
               if (out_ack) begin
                  addr_d    = addr_q + ADDR_W'(1);
                  re_pend_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= csn_state ? ST_IDLE : ST_IGNORE;
         rd_cmd_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         out_q      <= 8'h00;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         re_pend_q  <= 1'b0;
         inc_pend_q <= 1'b0;
         rd_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cmd_q   <= rd_cmd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         out_q      <= out_d;
         we_q       <= we_d;
         re_q       <= re_d;
         re_pend_q  <= re_pend_d;
         inc_pend_q <= inc_pend_d;
         rd_vld_q   <= rd_vld_d;
      end
   end

   assign out_data  = out_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign bus_re    = re_q;

endmodule

// File: tb/tb_spi_cmd_proto.sv
// Directed bench for spi_cmd_proto: frame-level model of expected bus traffic
// and returned bytes, checked by a per-cycle monitor plus literal spot checks.
module tb_spi_cmd_proto;

   localparam int GAP = 10;
`ifdef SPI_CMD_PROTO_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_stb;
   logic [7:0] out_data;
   logic       out_ack;
   logic       csn_state;
   logic       csn_rise;
   logic       csn_fall;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata = 8'h00;

   int total = 0;
   int bad   = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int w0, r0;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  data_q[$];
   logic [7:0]  got_q[$];
   logic        chk_zero = 1'b0;
   logic [7:0]  fall_out;
   logic [15:0] mon_w;
   logic [7:0]  mon_r;

   always #5 clk = ~clk;

   spi_cmd_proto #(.ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_stb    (in_stb),
      .out_data  (out_data),
      .out_ack   (out_ack),
      .csn_state (csn_state),
      .csn_rise  (csn_rise),
      .csn_fall  (csn_fall),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_rdata (bus_rdata)
   );

   // Register-bus slave: read data valid the cycle after bus_re.
   always @(posedge clk) begin
      if (bus_re) bus_rdata <= mem[bus_addr];
      if (bus_we) mem[bus_addr] = bus_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare of bus strobes and idle output against the model queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_we || bus_re) check("we_re_exclusive", 32'(bus_we & bus_re), 0);
         if (bus_we) begin
            we_cnt++;
            if (exp_wr.size() == 0) check("unexpected_we", 32'(bus_we), 0);
            else begin
               mon_w = exp_wr.pop_front();
               check("wr_addr_data", {16'd0, bus_addr, bus_wdata}, {16'd0, mon_w});
            end
         end
         if (bus_re) begin
            re_cnt++;
            if (exp_rd.size() == 0) check("unexpected_re", 32'(bus_re), 0);
            else begin
               mon_r = exp_rd.pop_front();
               check("rd_addr", {24'd0, bus_addr}, {24'd0, mon_r});
            end
         end
         if (chk_zero) check("out_zero", {24'd0, out_data}, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_data = b;
      in_stb  = 1'b1;
      step(1);
      in_stb  = 1'b0;
      step(GAP);
   endtask

   task automatic cs_fall();
      csn_state = 1'b0;
      csn_fall  = 1'b1;
      step(1);
      csn_fall  = 1'b0;
      fall_out  = out_data;
      step(GAP);
   endtask

   task automatic cs_rise();
      csn_state = 1'b1;
      csn_rise  = 1'b1;
      step(1);
      csn_rise  = 1'b0;
      step(GAP);
   endtask

   task automatic ack();
      out_ack = 1'b1;
      step(1);
      out_ack = 1'b0;
   endtask

   task automatic wr_frame(input logic [7:0] a);
      logic [7:0] ad;
      chk_zero = 1'b0;
      cs_fall();
      send(8'h02);
      chk_zero = 1'b1;
      send(a);
      ad = a;
      foreach (data_q[i]) begin
         exp_wr.push_back({ad, data_q[i]});
         ref_mem[ad] = data_q[i];
         send(data_q[i]);
         ad++;
      end
      cs_rise();
   endtask

   task automatic rd_frame(input logic [7:0] a, input int n);
      logic [7:0] ad, nx;
      chk_zero = 1'b0;
      cs_fall();
      send(8'h03);
      chk_zero = 1'b1;
      ad = a;
      for (int i = 0; i <= n; i++) begin
         exp_rd.push_back(ad);
         ad++;
      end
      in_data = a;
      in_stb  = 1'b1;
      step(1);
      in_stb  = 1'b0;
      chk_zero = 1'b0;
      step(1);
      check("rd_lat_c2", {24'd0, out_data}, 0);
      step(1);
      check("rd_lat_c3", {24'd0, out_data}, {24'd0, ref_mem[a]});
      step(GAP - 2);
      ack();
      step(2);
      send(8'h00);
      ad = a;
      for (int i = 0; i < n; i++) begin
         nx = ad + 8'd1;
         check("rd_byte", {24'd0, out_data}, {24'd0, ref_mem[ad]});
         got_q.push_back(out_data);
         ack();
         step(2);
         check("ack_lat_c3", {24'd0, out_data}, {24'd0, ref_mem[ad]});
         step(1);
         check("ack_lat_c4", {24'd0, out_data}, {24'd0, ref_mem[nx]});
         ad = nx;
         step(2);
         send(8'h00);
      end
      cs_rise();
      chk_zero = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst = 1'b1; in_data = 8'h00; in_stb = 1'b0; out_ack = 1'b0;
      csn_state = 1'b1; csn_rise = 1'b0; csn_fall = 1'b0;
      step(3);
      check("rst_out_data", {24'd0, out_data}, 0);
      check("rst_bus_addr", {24'd0, bus_addr}, 0);
      check("rst_bus_wdata", {24'd0, bus_wdata}, 0);
      check("rst_bus_we", 32'(bus_we), 0);
      check("rst_bus_re", 32'(bus_re), 0);
      rst = 1'b0;
      step(2);
      chk_zero = 1'b1;

      // Burst write 02,10,AA,BB,CC
      w0 = we_cnt; r0 = re_cnt;
      data_q = '{8'hAA, 8'hBB, 8'hCC};
      wr_frame(8'h10);
      check("t_wr_we_cnt", we_cnt - w0, 3);
      check("t_wr_re_cnt", re_cnt - r0, 0);
      check("t_wr_mem10", {24'd0, mem[8'h10]}, 32'hAA);
      check("t_wr_mem11", {24'd0, mem[8'h11]}, 32'hBB);
      check("t_wr_mem12", {24'd0, mem[8'h12]}, 32'hCC);

      // Burst read 03,20,xx,xx,xx,xx
      mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33;
      ref_mem[8'h20] = 8'h11; ref_mem[8'h21] = 8'h22; ref_mem[8'h22] = 8'h33;
      w0 = we_cnt; r0 = re_cnt;
      got_q.delete();
      rd_frame(8'h20, 3);
      check("t_rd_nbytes", got_q.size(), 3);
      check("t_rd_byte0", {24'd0, got_q[0]}, 32'h11);
      check("t_rd_byte1", {24'd0, got_q[1]}, 32'h22);
      check("t_rd_byte2", {24'd0, got_q[2]}, 32'h33);
      check("t_rd_re_cnt", re_cnt - r0, 4);
      check("t_rd_we_cnt", we_cnt - w0, 0);

      // Address wrap 0xFF -> 0x00
      data_q = '{8'h01, 8'h02};
      wr_frame(8'hFF);
      check("t_wrap_memff", {24'd0, mem[8'hFF]}, 32'h01);
      check("t_wrap_mem00", {24'd0, mem[8'h00]}, 32'h02);

      // Unknown command, then a good write
      w0 = we_cnt; r0 = re_cnt;
      chk_zero = 1'b0;
      cs_fall();
      send(8'h5A);
      chk_zero = 1'b1;
      send(8'h01);
      send(8'h02);
      cs_rise();
      check("t_ign_we_cnt", we_cnt - w0, 0);
      check("t_ign_re_cnt", re_cnt - r0, 0);
      data_q = '{8'h77};
      wr_frame(8'h00);
      check("t_ign_mem00", {24'd0, mem[8'h00]}, 32'h77);

      // csn_rise coincident with a data byte drops that byte
      w0 = we_cnt;
      chk_zero = 1'b0;
      cs_fall();
      send(8'h02);
      chk_zero = 1'b1;
      send(8'h40);
      exp_wr.push_back({8'h40, 8'h55});
      ref_mem[8'h40] = 8'h55;
      send(8'h55);
      in_data = 8'h66; in_stb = 1'b1; csn_rise = 1'b1; csn_state = 1'b1;
      step(1);
      in_stb = 1'b0; csn_rise = 1'b0;
      step(GAP);
      check("t_rise_we_cnt", we_cnt - w0, 1);
      check("t_rise_mem41", {24'd0, mem[8'h41]}, 0);

      // Reset mid-frame with CS low: frame is ignored until the next one
      w0 = we_cnt; r0 = re_cnt;
      chk_zero = 1'b0;
      cs_fall();
      send(8'h02);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk_zero = 1'b1;
      check("t_mrst_addr", {24'd0, bus_addr}, 0);
      send(8'h50);
      send(8'h99);
      send(8'hA5);
      check("t_mrst_we_cnt", we_cnt - w0, 0);
      check("t_mrst_re_cnt", re_cnt - r0, 0);
      cs_rise();
      data_q = '{8'h99};
      wr_frame(8'h50);
      check("t_mrst_mem50", {24'd0, mem[8'h50]}, 32'h99);

      // Status byte sequence from a fresh reset
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      data_q = '{8'h01};
      wr_frame(8'h60);
      data_q = '{8'h02};
      wr_frame(8'h61);
      check("st_frame2", {24'd0, fall_out}, STATUS_EN ? 32'h10 : 32'h00);
      chk_zero = 1'b0;
      cs_fall();
      check("st_frame3", {24'd0, fall_out}, STATUS_EN ? 32'h20 : 32'h00);
      send(8'h7E);
      chk_zero = 1'b1;
      send(8'h00);
      cs_rise();
      chk_zero = 1'b0;
      cs_fall();
      check("st_after_invalid", {24'd0, fall_out}, STATUS_EN ? 32'h31 : 32'h00);
      cs_rise();
      cs_fall();
      check("st_frame5", {24'd0, fall_out}, STATUS_EN ? 32'h40 : 32'h00);
      send(8'h03);
      cs_rise();
      cs_fall();
      check("st_after_abort", {24'd0, fall_out}, STATUS_EN ? 32'h52 : 32'h00);
      cs_rise();

      step(5);
      check("exp_wr_drained", exp_wr.size(), 0);
      check("exp_rd_drained", exp_rd.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
